// File: rtl/pwm_pulse_capture.sv
// rtl/pwm_pulse_capture.sv - PWM pin synchronizer, glitch filter and pulse-width measurement; optional PWM_CAPTURE_PERIOD_EN adds period_out
module pwm_pulse_capture #(
    parameter int WIDTH_BITS   = 12,
    parameter int MAX_WIDTH    = 2000,
    parameter int FILTER_LEN   = 3,
    parameter int NOSIG_CYCLES = 25000,
    parameter int PERIOD_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  pwm_in,
    output logic [WIDTH_BITS-1:0] width_out,
    output logic                  width_valid,
    output logic                  overflow,
`ifdef PWM_CAPTURE_PERIOD_EN
    output logic                  no_signal,
    output logic [PERIOD_BITS-1:0] period_out
`else
    output logic                  no_signal
`endif
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int NW = $clog2(NOSIG_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_RISE, MEASURE} state_t;

    state_t state, state_n;

    logic          sync1, sync2;
    logic          filt, filt_d;
    logic [FW-1:0] fcnt;
    logic [WIDTH_BITS-1:0] cnt;
    logic [NW-1:0] ncnt;
    logic          rise, fall, at_limit;

    // Input path runs regardless of ena so the filtered level is always current.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            filt   <= 1'b0;
            filt_d <= 1'b0;
            fcnt   <= '0;
        end else begin
            sync1  <= pwm_in;
            sync2  <= sync1;
            filt_d <= filt;
            if (sync2 != filt) begin
                if (fcnt == FW'(FILTER_LEN - 1)) begin
                    filt <= sync2;
                    fcnt <= '0;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end else begin
                fcnt <= '0;
            end
        end
    end

    assign rise     = filt & ~filt_d;
    assign fall     = ~filt & filt_d;
    assign at_limit = (cnt == WIDTH_BITS'(MAX_WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (!ena) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:      state_n = WAIT_LOW;
                WAIT_LOW:  if (!filt) state_n = WAIT_RISE;
                WAIT_RISE: if (rise) state_n = MEASURE;
                MEASURE: begin
                    if (fall) begin
                        state_n = WAIT_RISE;
                    end else if (filt && at_limit) begin
                        state_n = WAIT_LOW;
                    end
                end
                default:   state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width_out   <= '0;
            width_valid <= 1'b0;
            overflow    <= 1'b0;
            no_signal   <= 1'b0;
            cnt         <= '0;
            ncnt        <= '0;
        end else begin
            width_valid <= 1'b0;
            if (!ena) begin
                overflow  <= 1'b0;
                no_signal <= 1'b0;
                cnt       <= '0;
                ncnt      <= '0;
            end else begin
                if (state == WAIT_RISE && rise) begin
                    cnt <= WIDTH_BITS'(1);
                end else if (state == MEASURE) begin
                    if (fall) begin
                        width_out   <= cnt;
                        width_valid <= 1'b1;
                        overflow    <= 1'b0;
                    end else if (filt) begin
                        if (at_limit) begin
                            cnt      <= WIDTH_BITS'(MAX_WIDTH);
                            overflow <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                // Silence timer only advances while waiting for an edge.
                if (state == WAIT_LOW || state == WAIT_RISE) begin
                    if (state == WAIT_RISE && rise) begin
                        ncnt      <= '0;
                        no_signal <= 1'b0;
                    end else if (ncnt != NW'(NOSIG_CYCLES)) begin
                        ncnt <= ncnt + 1'b1;
                        if (ncnt == NW'(NOSIG_CYCLES - 1)) begin
                            no_signal <= 1'b1;
                        end
                    end
                end
            end
        end
    end

`ifdef PWM_CAPTURE_PERIOD_EN
    logic [PERIOD_BITS-1:0] pcnt, pend;
    logic                   have_prev, pend_v;

    // A period is latched at the rise that closes it and published with that pulse's strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt       <= '0;
            pend       <= '0;
            pend_v     <= 1'b0;
            have_prev  <= 1'b0;
            period_out <= '0;
        end else if (!ena || state == IDLE || state == WAIT_LOW) begin
            have_prev <= 1'b0;
            pend_v    <= 1'b0;
        end else begin
            if (pcnt != '1) begin
                pcnt <= pcnt + 1'b1;
            end
            if (state == WAIT_RISE && rise) begin
                pcnt      <= PERIOD_BITS'(1);
                have_prev <= 1'b1;
                if (have_prev) begin
                    pend   <= pcnt;
                    pend_v <= 1'b1;
                end
            end
            if (state == MEASURE && fall && pend_v) begin
                period_out <= pend;
                pend_v     <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pwm_pulse_capture.sv
// tb/tb_pwm_pulse_capture.sv - directed and randomized pulse trains checked against a pulse-level width model
module tb_pwm_pulse_capture;

    localparam int FL = 3;
    localparam int MW = 2000;
    localparam int NS = 25000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic        pwm_in = 1'b0;
    logic [11:0] width_out;
    logic        width_valid;
    logic        overflow;
    logic        no_signal;
`ifdef PWM_CAPTURE_PERIOD_EN
    logic [15:0] period_out;
`endif

    pwm_pulse_capture #(
        .WIDTH_BITS(12), .MAX_WIDTH(MW), .FILTER_LEN(FL), .NOSIG_CYCLES(NS), .PERIOD_BITS(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .pwm_in(pwm_in),
        .width_out(width_out), .width_valid(width_valid),
        .overflow(overflow),
`ifdef PWM_CAPTURE_PERIOD_EN
        .no_signal(no_signal),
        .period_out(period_out)
`else
        .no_signal(no_signal)
`endif
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   sc[$];
    int   sw[$];
    logic last_wv = 1'b0;
    int   model_w = 0;
    logic model_ovf = 1'b0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One cycle: sample outputs on the falling edge, log strobes.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (width_valid === 1'b1) begin
            chk("no_back_to_back", {31'b0, last_wv}, 32'd0);
            sc.push_back(cyc);
            sw.push_back(int'(width_out));
        end
        last_wv = width_valid;
    endtask

    task automatic drive(logic lvl, int n);
        repeat (n) begin
            tick();
            pwm_in = lvl;
        end
    endtask

    // High a, optional low dip d then high b, then low l; filtered high time is the whole span.
    task automatic apply_pulse(string tag, int a, int d, int b, int l);
        int n0, hi, fall;
        n0 = sc.size();
        hi = a;
        drive(1'b1, a);
        if (d > 0) begin
            drive(1'b0, d);
            drive(1'b1, b);
            hi = a + d + b;
        end
        fall = cyc + 1;
        drive(1'b0, l);
        if (hi < FL) begin
            chk({tag, "_strobes"}, sc.size() - n0, 0);
        end else if (hi < MW) begin
            chk({tag, "_strobes"}, sc.size() - n0, 1);
            if (sc.size() > n0) begin
                chk({tag, "_strobe_cycle"}, sc[n0], fall + FL + 3);
                chk({tag, "_strobe_width"}, sw[n0], hi);
            end
            model_w   = hi;
            model_ovf = 1'b0;
        end else begin
            chk({tag, "_strobes"}, sc.size() - n0, 0);
            model_ovf = 1'b1;
        end
        chk({tag, "_width_out"}, {20'b0, width_out}, model_w);
        chk({tag, "_overflow"}, {31'b0, overflow}, {31'b0, model_ovf});
        chk({tag, "_no_signal"}, {31'b0, no_signal}, 32'd0);
    endtask

    initial begin
        int n0, fall, kind, a, d, b, l;

        repeat (3) tick();
        chk("rst_width_out", {20'b0, width_out}, 32'd0);
        chk("rst_width_valid", {31'b0, width_valid}, 32'd0);
        chk("rst_overflow", {31'b0, overflow}, 32'd0);
        chk("rst_no_signal", {31'b0, no_signal}, 32'd0);
        rst_n = 1'b1;
        ena   = 1'b1;
        drive(1'b0, 20);

        repeat (3) apply_pulse("steady", 1500, 0, 0, 2000);
        apply_pulse("glitch", FL - 1, 0, 0, 100);
        apply_pulse("stuck_high", 2500, 0, 0, 100);
        apply_pulse("after_ovf", 1200, 0, 0, 100);
        apply_pulse("min_width", FL, 0, 0, 50);
        apply_pulse("max_minus1", MW - 1, 0, 0, 50);
        apply_pulse("at_max", MW, 0, 0, 50);
        apply_pulse("dip", 400, FL - 1, 300, 50);

        n0 = sc.size();
        drive(1'b1, 700);
        ena = 1'b0;
        model_ovf = 1'b0;
        drive(1'b1, 5);
        chk("dis_overflow", {31'b0, overflow}, 32'd0);
        chk("dis_no_signal", {31'b0, no_signal}, 32'd0);
        chk("dis_width_hold", {20'b0, width_out}, model_w);
        ena = 1'b1;
        drive(1'b1, 300);
        drive(1'b0, 50);
        chk("dis_discarded", sc.size() - n0, 0);
        apply_pulse("reenable", 1100, 0, 0, 50);

        drive(1'b0, 24000);
        chk("nosig_early", {31'b0, no_signal}, 32'd0);
        drive(1'b0, 1100);
        chk("nosig_set", {31'b0, no_signal}, 32'd1);
        n0 = sc.size();
        drive(1'b1, FL + 5);
        chk("nosig_cleared", {31'b0, no_signal}, 32'd0);
        drive(1'b1, 1500 - (FL + 5));
        fall = cyc + 1;
        drive(1'b0, 50);
        chk("nosig_strobes", sc.size() - n0, 1);
        if (sc.size() > n0) begin
            chk("nosig_cycle", sc[n0], fall + FL + 3);
            chk("nosig_width", sw[n0], 1500);
        end
        model_w = 1500;

        for (int i = 0; i < 14; i++) begin
            kind = $urandom_range(0, 3);
            l    = $urandom_range(20, 300);
            d    = 0;
            b    = 0;
            case (kind)
                0: a = $urandom_range(1, FL - 1);
                1: a = $urandom_range(FL, 2100);
                2: begin
                    a = $urandom_range(FL, 900);
                    d = $urandom_range(1, FL - 1);
                    b = $urandom_range(FL, 900);
                end
                default: begin
                    case ($urandom_range(0, 2))
                        0: a = FL;
                        1: a = MW - 1;
                        default: a = MW;
                    endcase
                end
            endcase
            apply_pulse($sformatf("rand%0d", i), a, d, b, l);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
